// File: rtl/memory_interface_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// Holds the FSM state encoding, the core's READ/WRITE and ENABLE/DISABLE values,
// the port-select constants and the saturating streak helper.
package memory_interface_arbiter_pkg;

    // Grant FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Memory access direction, same encoding as the core's dmem_state
    localparam logic READ    = 1'b0;
    localparam logic WRITE   = 1'b1;

    // Enable encoding used on mem_enable
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Which requester owns the memory port
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    // Instruction fetches always read the full word
    localparam logic [3:0] FULL_WORD_MASK = 4'b1111;

    // Saturating increment of the data-grant streak
    function automatic logic [3:0] streak_inc(input logic [3:0] cur, input logic [3:0] max);
        return (cur >= max) ? max : cur + 4'd1;
    endfunction

endpackage

// File: rtl/memory_interface_arbiter_priority_select.sv
// Purpose : picks the winner between instruction and data requests; data wins unless
//           the instruction port has watched DATA_STREAK_MAX data grants in a row.
// Latency : combinational choice; the streak register updates on the granting edge.
// Backpressure: grants are only produced while arb_enable (FSM idle) is high.
//
// Ports:
//   clk, reset         clock and asynchronous active-high reset
//   arb_enable         FSM is in IDLE and may accept a new grant
//   imem_enable        instruction request pending
//   dmem_enable        data request pending
//   grant_valid        a grant is issued this cycle
//   grant_sel          GRANT_I or GRANT_D, meaningful when grant_valid=1
module arbiter_priority_select
    import memory_interface_arbiter_pkg::*;
#(
    parameter int DATA_STREAK_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_enable,
    input  logic imem_enable,
    input  logic dmem_enable,
    output logic grant_valid,
    output logic grant_sel
);

    localparam logic [3:0] STREAK_MAX = 4'(DATA_STREAK_MAX);

    logic [3:0] streak;
    logic       data_blocked;

    always_comb begin
        // Once the streak is exhausted a waiting instruction fetch must go next
        data_blocked = imem_enable && (streak == STREAK_MAX);
        grant_valid  = arb_enable && (imem_enable || dmem_enable);
        grant_sel    = (dmem_enable && !data_blocked) ? GRANT_D : GRANT_I;
    end

    // The streak only counts data grants that overtook a waiting instruction fetch;
    // any other grant means the instruction port is not being starved, so restart.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak <= 4'd0;
        end else if (grant_valid) begin
            if ((grant_sel == GRANT_D) && imem_enable) begin
                streak <= streak_inc(streak, STREAK_MAX);
            end else begin
                streak <= 4'd0;
            end
        end
    end

endmodule

// File: rtl/memory_interface_arbiter.sv
// Purpose : shares one external memory port between instruction fetch and data access.
// Latency : IDLE grant -> WAIT (>=1 cycle) -> RESP ready pulse; 3 cycles best case.
// Backpressure: requesters hold enable until their one-cycle ready; memory stalls via mem_valid.
//
// Optional feature macro: MEMORY_ARBITER_PERF_COUNTERS_EN adds perf_imem_grants,
// perf_dmem_grants and perf_imem_stall_cycles (32-bit wrapping counters).
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   imem_enable/imem_address         instruction read request (held until imem_ready)
//   imem_data/imem_ready/imem_error  registered response, valid while imem_ready=1
//   dmem_enable/state/address/
//   dmem_frame_mask/dmem_wdata       data request (held until dmem_ready)
//   dmem_rdata/dmem_ready/dmem_error registered response, valid while dmem_ready=1
//   mem_enable/state/address/
//   mem_frame_mask/mem_wdata         registered request towards memory
//   mem_rdata/mem_valid              memory completion, honoured only while mem_enable=1
module memory_interface_arbiter
    import memory_interface_arbiter_pkg::*;
#(
    parameter int          DATA_STREAK_MAX = 4,
    parameter int          TIMEOUT_CYCLES  = 64,
    parameter logic [31:0] ERROR_WORD      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        imem_enable,
    input  logic [31:0] imem_address,
    output logic [31:0] imem_data,
    output logic        imem_ready,
    output logic        imem_error,

    input  logic        dmem_enable,
    input  logic        dmem_state,
    input  logic [31:0] dmem_address,
    input  logic [3:0]  dmem_frame_mask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        dmem_error,

    output logic        mem_enable,
    output logic        mem_state,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_frame_mask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid
`ifdef MEMORY_ARBITER_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_imem_grants,
    output logic [31:0] perf_dmem_grants,
    output logic [31:0] perf_imem_stall_cycles
`endif
);

    localparam int             TCW       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TCW-1:0] WAIT_LAST = TCW'(TIMEOUT_CYCLES - 1);

    arb_state_t     state;
    logic           grant_port;   // owner of the access in flight
    logic [TCW-1:0] wait_cnt;     // cycles already spent in WAIT
    logic           grant_valid;
    logic           grant_sel;

    arbiter_priority_select #(
        .DATA_STREAK_MAX (DATA_STREAK_MAX)
    ) u_select (
        .clk         (clk),
        .reset       (reset),
        .arb_enable  (state == IDLE),
        .imem_enable (imem_enable),
        .dmem_enable (dmem_enable),
        .grant_valid (grant_valid),
        .grant_sel   (grant_sel)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            grant_port     <= GRANT_I;
            wait_cnt       <= '0;
            mem_enable     <= DISABLE;
            mem_state      <= READ;
            mem_address    <= 32'd0;
            mem_frame_mask <= 4'd0;
            mem_wdata      <= 32'd0;
            imem_data      <= 32'd0;
            imem_ready     <= 1'b0;
            imem_error     <= 1'b0;
            dmem_rdata     <= 32'd0;
            dmem_ready     <= 1'b0;
            dmem_error     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        grant_port <= grant_sel;
                        wait_cnt   <= '0;
                        mem_enable <= ENABLE;
                        state      <= WAIT;
                        if (grant_sel == GRANT_D) begin
                            mem_state      <= dmem_state;
                            mem_address    <= dmem_address;
                            mem_frame_mask <= dmem_frame_mask;
                            mem_wdata      <= dmem_wdata;
                        end else begin
                            mem_state      <= READ;
                            mem_address    <= imem_address;
                            mem_frame_mask <= FULL_WORD_MASK;
                            mem_wdata      <= 32'd0;
                        end
                    end
                end

                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // A completion arriving in the last allowed cycle still wins over the abort
                    if (mem_valid) begin
                        mem_enable <= DISABLE;
                        state      <= RESP;
                        if (grant_port == GRANT_D) begin
                            dmem_ready <= 1'b1;
                            dmem_error <= 1'b0;
                            dmem_rdata <= (mem_state == WRITE) ? 32'd0 : mem_rdata;
                        end else begin
                            imem_ready <= 1'b1;
                            imem_error <= 1'b0;
                            imem_data  <= mem_rdata;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        mem_enable <= DISABLE;
                        state      <= RESP;
                        if (grant_port == GRANT_D) begin
                            dmem_ready <= 1'b1;
                            dmem_error <= 1'b1;
                            dmem_rdata <= ERROR_WORD;
                        end else begin
                            imem_ready <= 1'b1;
                            imem_error <= 1'b1;
                            imem_data  <= ERROR_WORD;
                        end
                    end
                end

                RESP: begin
                    // Response lives exactly one cycle; arbitration restarts next cycle,
                    // after the requester has had the chance to drop or renew its enable.
                    imem_ready <= 1'b0;
                    imem_error <= 1'b0;
                    imem_data  <= 32'd0;
                    dmem_ready <= 1'b0;
                    dmem_error <= 1'b0;
                    dmem_rdata <= 32'd0;
                    state      <= IDLE;
                end

                default: begin
                    mem_enable <= DISABLE;
                    state      <= IDLE;
                end
            endcase
        end
    end

`ifdef MEMORY_ARBITER_PERF_COUNTERS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_imem_grants       <= 32'd0;
            perf_dmem_grants       <= 32'd0;
            perf_imem_stall_cycles <= 32'd0;
        end else begin
            if (grant_valid && (grant_sel == GRANT_I)) begin
                perf_imem_grants <= perf_imem_grants + 32'd1;
            end
            if (grant_valid && (grant_sel == GRANT_D)) begin
                perf_dmem_grants <= perf_dmem_grants + 32'd1;
            end
            // Every cycle a fetch is pending except the one delivering its response
            if (imem_enable && !((state == RESP) && (grant_port == GRANT_I))) begin
                perf_imem_stall_cycles <= perf_imem_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_memory_interface_arbiter.sv
`timescale 1ns/1ps
module tb_memory_interface_arbiter;

    localparam int          STREAK = 4;
    localparam int          TMO    = 8;
    localparam logic [31:0] ERRW   = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_enable, imem_ready, imem_error;
    logic [31:0] imem_address, imem_data;
    logic        dmem_enable, dmem_state, dmem_ready, dmem_error;
    logic [31:0] dmem_address, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_frame_mask;
    logic        mem_enable, mem_state, mem_valid;
    logic [31:0] mem_address, mem_wdata, mem_rdata;
    logic [3:0]  mem_frame_mask;
`ifdef MEMORY_ARBITER_PERF_COUNTERS_EN
    logic [31:0] perf_imem_grants, perf_dmem_grants, perf_imem_stall_cycles;
`endif

    memory_interface_arbiter #(
        .DATA_STREAK_MAX (STREAK),
        .TIMEOUT_CYCLES  (TMO),
        .ERROR_WORD      (ERRW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_enable     (imem_enable),
        .imem_address    (imem_address),
        .imem_data       (imem_data),
        .imem_ready      (imem_ready),
        .imem_error      (imem_error),
        .dmem_enable     (dmem_enable),
        .dmem_state      (dmem_state),
        .dmem_address    (dmem_address),
        .dmem_frame_mask (dmem_frame_mask),
        .dmem_wdata      (dmem_wdata),
        .dmem_rdata      (dmem_rdata),
        .dmem_ready      (dmem_ready),
        .dmem_error      (dmem_error),
        .mem_enable      (mem_enable),
        .mem_state       (mem_state),
        .mem_address     (mem_address),
        .mem_frame_mask  (mem_frame_mask),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_valid       (mem_valid)
`ifdef MEMORY_ARBITER_PERF_COUNTERS_EN
        ,
        .perf_imem_grants       (perf_imem_grants),
        .perf_dmem_grants       (perf_dmem_grants),
        .perf_imem_stall_cycles (perf_imem_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    int    checks = 0;
    int    errors = 0;
    exp_t  exp_i[$];
    exp_t  exp_d[$];
    logic [31:0] mem_store [logic [31:0]];  // contents of the emulated memory
    logic [31:0] ref_mem   [logic [31:0]];  // reference model's view of memory
    bit    resp_on  = 1'b1;
    bit    rand_lat = 1'b0;
    int    streak_m = 0;
    string glog = "";
    int    n_ig = 0, n_dg = 0, stall_cnt = 0, en_cycles = 0;
    logic  pi_s = 1'b0, pd_s = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // mask bit3 selects byte[7:0], bit0 selects byte[31:24]
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (m[3-b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Request lines as they were at the arbitration edge
    always @(posedge clk) begin
        pi_s = imem_enable;
        pd_s = dmem_enable;
    end

    // Checks a fresh grant against the arbitration rules and the requester's fields
    task automatic grant_check();
        logic act_d, exp_dg;
        act_d  = (mem_address[31:28] == 4'h1);
        exp_dg = pd_s && !(pi_s && (streak_m == STREAK));
        chk("grant_had_request", {31'd0, pi_s | pd_s}, 32'd1);
        chk("grant_port", {31'd0, act_d}, {31'd0, exp_dg});
        if (act_d) begin
            n_dg++;
            glog = {glog, "D"};
            chk("mem_address_d", mem_address, dmem_address);
            chk("mem_state_d", {31'd0, mem_state}, {31'd0, dmem_state});
            chk("mem_mask_d", {28'd0, mem_frame_mask}, {28'd0, dmem_frame_mask});
            chk("mem_wdata_d", mem_wdata, dmem_wdata);
            streak_m = pi_s ? ((streak_m < STREAK) ? streak_m + 1 : STREAK) : 0;
        end else begin
            n_ig++;
            glog = {glog, "I"};
            chk("mem_address_i", mem_address, imem_address);
            chk("mem_state_i", {31'd0, mem_state}, 32'd0);
            chk("mem_mask_i", {28'd0, mem_frame_mask}, 32'h0000_000F);
            streak_m = 0;
        end
    endtask

    // Emulated memory: answers after 0..3 extra WAIT cycles, or never when resp_on=0
    initial begin
        bit busy;
        int dl;
        busy = 1'b0;
        dl = 0;
        mem_valid = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            mem_valid = 1'b0;
            mem_rdata = 32'd0;
            if (!mem_enable || reset) begin
                busy = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    grant_check();
                    dl = rand_lat ? int'($urandom_range(0, 3)) : 0;
                end
                if (resp_on) begin
                    if (dl == 0) begin
                        mem_valid = 1'b1;
                        if (mem_state) begin
                            mem_store[mem_address] = merge(mem_store.exists(mem_address) ?
                                mem_store[mem_address] : init_word(mem_address),
                                mem_wdata, mem_frame_mask);
                        end else begin
                            mem_rdata = mem_store.exists(mem_address) ?
                                mem_store[mem_address] : init_word(mem_address);
                        end
                        dl = -1;
                    end else if (dl > 0) begin
                        dl--;
                    end
                end
            end
        end
    end

    // Scoreboard monitor: pops the expected response whenever a ready pulse appears
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_enable) en_cycles++;
            if (!reset && imem_enable && !imem_ready) stall_cnt++;
            if (imem_ready || dmem_ready)
                chk("mem_enable_low_in_resp", {31'd0, mem_enable}, 32'd0);
            if (imem_ready) begin
                chk("dmem_idle_ready", {31'd0, dmem_ready}, 32'd0);
                chk("dmem_idle_data", dmem_rdata, 32'd0);
                chk("dmem_idle_error", {31'd0, dmem_error}, 32'd0);
                if (exp_i.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL imem_unexpected_ready: got ready=1, expected no response");
                end else begin
                    e = exp_i.pop_front();
                    chk("imem_data", imem_data, e.data);
                    chk("imem_error", {31'd0, imem_error}, {31'd0, e.err});
                end
            end
            if (dmem_ready) begin
                chk("imem_idle_data", imem_data, 32'd0);
                chk("imem_idle_error", {31'd0, imem_error}, 32'd0);
                if (exp_d.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dmem_unexpected_ready: got ready=1, expected no response");
                end else begin
                    e = exp_d.pop_front();
                    chk("dmem_rdata", dmem_rdata, e.data);
                    chk("dmem_error", {31'd0, dmem_error}, {31'd0, e.err});
                end
            end
        end
    end

    // Requesters: called at posedge+#1, return at posedge+#1 after their ready pulse
    task automatic imem_req(input logic [31:0] addr, output int lat);
        exp_t e;
        e.data = ref_rd(addr);
        e.err  = 1'b0;
        exp_i.push_back(e);
        imem_enable  = 1'b1;
        imem_address = addr;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!imem_ready && lat < 100);
        if (!imem_ready) begin
            checks++; errors++;
            $display("FAIL imem_ready_timeout: got no ready after %0d cycles, expected a pulse", lat);
        end
        @(posedge clk); #1;
        imem_enable  = 1'b0;
        imem_address = 32'd0;
    endtask

    task automatic dmem_req(input logic wr, input logic [31:0] addr, input logic [3:0] m,
                            input logic [31:0] wd, input bit tmo, output int lat);
        exp_t e;
        e.err = tmo;
        if (tmo) begin
            e.data = ERRW;
        end else if (wr) begin
            e.data = 32'd0;
            ref_mem[addr] = merge(ref_rd(addr), wd, m);
        end else begin
            e.data = ref_rd(addr);
        end
        exp_d.push_back(e);
        dmem_enable     = 1'b1;
        dmem_state      = wr;
        dmem_address    = addr;
        dmem_frame_mask = m;
        dmem_wdata      = wd;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!dmem_ready && lat < 100);
        if (!dmem_ready) begin
            checks++; errors++;
            $display("FAIL dmem_ready_timeout: got no ready after %0d cycles, expected a pulse", lat);
        end
        @(posedge clk); #1;
        dmem_enable     = 1'b0;
        dmem_state      = 1'b0;
        dmem_address    = 32'd0;
        dmem_frame_mask = 4'd0;
        dmem_wdata      = 32'd0;
    endtask

    task automatic imem_stream(input int n, input bit gaps);
        int lat;
        for (int k = 0; k < n; k++) begin
            imem_req(32'h0000_0100 + 32'($urandom_range(0, 63)) * 4, lat);
            if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic dmem_stream(input int n, input bit gaps);
        int lat;
        for (int k = 0; k < n; k++) begin
            dmem_req(1'($urandom_range(0, 1)), 32'h1000_0000 + 32'($urandom_range(0, 15)) * 4,
                     4'($urandom_range(1, 15)), $urandom, 1'b0, lat);
            if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, n;
        imem_enable = 1'b0; imem_address = 32'd0;
        dmem_enable = 1'b0; dmem_state = 1'b0; dmem_address = 32'd0;
        dmem_frame_mask = 4'd0; dmem_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
        chk("rst_mem_state", {31'd0, mem_state}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_mask", {28'd0, mem_frame_mask}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_ready", {30'd0, imem_ready, dmem_ready}, 32'd0);
        chk("rst_data", imem_data | dmem_rdata, 32'd0);
        chk("rst_error", {30'd0, imem_error, dmem_error}, 32'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        // Single instruction read, best-case latency
        mem_store[32'h10] = 32'h13;
        ref_mem[32'h10]   = 32'h13;
        imem_req(32'h0000_0010, lat);
        chk("imem_latency", lat, 32'd3);

        // Byte write then read back
        dmem_req(1'b1, 32'h1000_0000, 4'b1000, 32'h41, 1'b0, lat);
        chk("dmem_write_latency", lat, 32'd3);
        dmem_req(1'b0, 32'h1000_0000, 4'b1111, 32'd0, 1'b0, lat);

        // Contention: both ports request continuously
        glog = "";
        fork
            imem_stream(2, 1'b0);
            dmem_stream(8, 1'b0);
        join
        checks++;
        if (glog != "DDDDIDDDDI") begin
            errors++;
            $display("FAIL grant_order: got %s, expected DDDDIDDDDI", glog);
        end

        // Timeout on a data read
        resp_on = 1'b0;
        en_cycles = 0;
        dmem_req(1'b0, 32'h1000_0004, 4'b1111, 32'd0, 1'b1, lat);
        chk("timeout_wait_cycles", en_cycles, TMO);
        chk("timeout_latency", lat, TMO + 2);

        // Reset in the middle of WAIT
        dmem_enable = 1'b1; dmem_state = 1'b0;
        dmem_address = 32'h1000_0008; dmem_frame_mask = 4'hF;
        n = 0;
        while (!mem_enable && n < 10) begin @(negedge clk); n++; end
        chk("mid_reset_granted", {31'd0, mem_enable}, 32'd1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_reset_mem_enable", {31'd0, mem_enable}, 32'd0);
        chk("mid_reset_ready", {30'd0, imem_ready, dmem_ready}, 32'd0);
        dmem_enable = 1'b0; dmem_address = 32'd0; dmem_frame_mask = 4'd0;
        streak_m = 0;
        resp_on = 1'b1;
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        imem_req(32'h0000_0104, lat);
        chk("post_reset_latency", lat, 32'd3);
        dmem_req(1'b0, 32'h1000_0000, 4'b1111, 32'd0, 1'b0, lat);

        // Randomised traffic with random memory latency
        rand_lat = 1'b1;
        fork
            imem_stream(25, 1'b1);
            dmem_stream(35, 1'b1);
        join
        rand_lat = 1'b0;

        // Fresh reset, then 5 instruction and 3 data accesses under contention
        @(negedge clk) reset = 1'b1;
        streak_m = 0; stall_cnt = 0; n_ig = 0; n_dg = 0;
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        fork
            imem_stream(5, 1'b0);
            dmem_stream(3, 1'b0);
        join
        repeat (2) @(posedge clk);
        #1;
`ifdef MEMORY_ARBITER_PERF_COUNTERS_EN
        chk("perf_imem_grants", perf_imem_grants, 32'd5);
        chk("perf_dmem_grants", perf_dmem_grants, 32'd3);
        chk("perf_imem_stall", perf_imem_stall_cycles, stall_cnt);
`endif
        chk("imem_grants_seen", n_ig, 32'd5);
        chk("exp_i_drained", exp_i.size(), 32'd0);
        chk("exp_d_drained", exp_d.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
